// File: rtl/pc_sequencer.sv
// pc_sequencer: picoMIPS program-memory fetch controller.
// Owns the program counter, captures the fetched instruction and sequences
// run / halt / single-step operation with stall, relative branch and jump.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   HALT  | idle, no fetch; waits for run or a rising edge on step_req
//   RUN   | fetch every non-stalled cycle
//   STEP  | perform exactly one non-stalled fetch, then return to HALT
module pc_sequencer #(
    parameter int Psize = 5,
    parameter int Isize = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             restart,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [Psize-1:0] branch_off,
    input  logic             jump_en,
    input  logic [Psize-1:0] jump_addr,
    input  logic [Isize-1:0] I_in,
    output logic [Psize-1:0] address,
    output logic [Isize-1:0] instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             wrap
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [Psize-1:0] PC_MAX = '1;
    localparam logic [Psize-1:0] PC_ONE = {{(Psize-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic             step_prev;
    logic             step_edge;
    logic             fetch;
    logic             take_inc;
    logic [Psize-1:0] next_pc;

    assign step_edge = step_req & ~step_prev;

    // State register, step edge history and registered halted flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= HALT;
            step_prev <= 1'b0;
            halted    <= 1'b1;
        end else begin
            state     <= state_next;
            step_prev <= step_req;
            halted    <= (state_next == HALT);
        end
    end

    // Next-state and fetch decision; restart and halt_req override everything.
    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        if (restart || halt_req) begin
            state_next = HALT;
        end else begin
            case (state)
                HALT: begin
                    if (run)
                        state_next = RUN;
                    else if (step_edge)
                        state_next = STEP;
                end
                RUN: begin
                    fetch = ~stall;
                end
                STEP: begin
                    if (!stall) begin
                        fetch      = 1'b1;
                        state_next = HALT;
                    end
                end
                default: state_next = HALT;
            endcase
        end
    end

    // Next program counter: jump beats branch beats increment; all wrap mod 2^Psize.
    always_comb begin
        next_pc  = address + PC_ONE;
        take_inc = 1'b1;
        if (jump_en) begin
            next_pc  = jump_addr;
            take_inc = 1'b0;
        end else if (branch_en) begin
            next_pc  = address + branch_off;
            take_inc = 1'b0;
        end
    end

    // PC, instruction capture, valid flag and increment-wrap pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            address     <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            wrap        <= 1'b0;
        end else if (restart) begin
            address     <= '0;
            instr_valid <= 1'b0;
            wrap        <= 1'b0;
        end else if (fetch) begin
            address     <= next_pc;
            instr       <= I_in;
            instr_valid <= 1'b1;
            wrap        <= take_inc && (address == PC_MAX);
        end else begin
            instr_valid <= 1'b0;
            wrap        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// behavioural model of the fetch controller.
module tb_pc_sequencer;

    localparam int PS = 5;
    localparam int IS = 16;
    localparam int DEPTH = 1 << PS;

    logic          clk;
    logic          n_reset;
    logic          run, halt_req, step_req, restart, stall;
    logic          branch_en, jump_en;
    logic [PS-1:0] branch_off, jump_addr;
    logic [IS-1:0] I_in;
    logic [PS-1:0] address;
    logic [IS-1:0] instr;
    logic          instr_valid, halted, wrap;

    logic [IS-1:0] mem [DEPTH];

    int ntests = 0;
    int nfail  = 0;

    // model: mode 0 = halted, 1 = running, 2 = single step pending
    int m_mode;
    int m_addr;
    int m_instr;
    int m_valid;
    int m_wrap;
    int m_step_prev;

    pc_sequencer #(.Psize(PS), .Isize(IS)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .run        (run),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .restart    (restart),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .I_in       (I_in),
        .address    (address),
        .instr      (instr),
        .instr_valid(instr_valid),
        .halted     (halted),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational program memory
    assign I_in = mem[address];

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_instr = 0; m_valid = 0; m_wrap = 0; m_step_prev = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".address"}, int'(address), m_addr);
        chk({tag, ".instr"}, int'(instr), m_instr);
        chk({tag, ".valid"}, int'(instr_valid), m_valid);
        chk({tag, ".halted"}, int'(halted), (m_mode == 0) ? 1 : 0);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
    endtask

    // Model: one clock of the fetch controller, from the current inputs.
    task automatic model_clock();
        bit do_fetch;
        int off;
        int nmode;
        do_fetch = 0;
        nmode = m_mode;
        if (restart || halt_req) begin
            nmode = 0;
        end else if (m_mode == 0) begin
            if (run) nmode = 1;
            else if (step_req && !m_step_prev) nmode = 2;
        end else if (m_mode == 1) begin
            do_fetch = !stall;
        end else if (!stall) begin
            do_fetch = 1;
            nmode = 0;
        end
        if (restart) begin
            m_addr = 0; m_valid = 0; m_wrap = 0;
        end else if (do_fetch) begin
            m_instr = int'(mem[m_addr]);
            m_valid = 1;
            m_wrap  = 0;
            if (jump_en) begin
                m_addr = int'(jump_addr);
            end else if (branch_en) begin
                off = branch_off[PS-1] ? int'(branch_off) - DEPTH : int'(branch_off);
                m_addr = (m_addr + off + DEPTH) % DEPTH;
            end else begin
                m_wrap = (m_addr == DEPTH - 1) ? 1 : 0;
                m_addr = (m_addr + 1) % DEPTH;
            end
        end else begin
            m_valid = 0; m_wrap = 0;
        end
        m_mode = nmode;
        m_step_prev = step_req ? 1 : 0;
    endtask

    task automatic cycle(input string tag);
        model_clock();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        run = 0; halt_req = 0; step_req = 0; restart = 0; stall = 0;
        branch_en = 0; jump_en = 0; branch_off = '0; jump_addr = '0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'hA000 + 16'(k);
        idle_inputs();
        n_reset = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        n_reset = 1'b1;

        // sequential run
        cycle("idle1");
        run = 1;
        cycle("run_enter");
        chk("run_halted_fall", int'(halted), 0);
        cycle("seq0");
        cycle("seq1");
        cycle("seq2");
        chk("seq_addr3", int'(address), 3);
        chk("seq_instr", int'(instr), 'hA002);

        // increment wrap from 31
        jump_en = 1; jump_addr = 5'd31;
        cycle("jump31");
        jump_en = 0;
        cycle("wrap_inc");
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_addr", int'(address), 0);
        cycle("wrap_after");
        chk("wrap_once", int'(wrap), 0);

        // branch wrap gives no pulse
        jump_en = 1; jump_addr = 5'd30;
        cycle("jump30");
        jump_en = 0; branch_en = 1; branch_off = 5'd2;
        cycle("branch_wrap");
        chk("branch_wrap_addr", int'(address), 0);
        chk("branch_wrap_nopulse", int'(wrap), 0);

        // negative branch and jump-over-branch priority
        branch_en = 0; jump_en = 1; jump_addr = 5'd10;
        cycle("jump10");
        jump_en = 0; branch_en = 1; branch_off = 5'b11101;
        cycle("branch_neg");
        chk("branch_neg_addr", int'(address), 7);
        branch_en = 0; jump_en = 1; jump_addr = 5'd4;
        cycle("jump4");
        branch_en = 1; branch_off = 5'd3; jump_addr = 5'd20;
        cycle("jump_prio");
        chk("jump_prio_addr", int'(address), 20);
        chk("jump_prio_instr", int'(instr), 'hA004);

        // stall
        branch_en = 0; jump_addr = 5'd6;
        cycle("jump6");
        jump_en = 0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            jump_en = 1; jump_addr = 5'd17;  // ignored while stalled
            cycle("stall");
            chk("stall_addr", int'(address), 6);
            chk("stall_valid", int'(instr_valid), 0);
        end
        jump_en = 0; stall = 0;
        cycle("stall_release");
        chk("stall_rel_instr", int'(instr), 'hA006);
        chk("stall_rel_addr", int'(address), 7);

        // halt and single step
        jump_en = 1; jump_addr = 5'd9;
        cycle("jump9");
        jump_en = 0; run = 0; halt_req = 1;
        cycle("halt");
        chk("halt_addr", int'(address), 9);
        halt_req = 0; step_req = 1;
        for (int i = 0; i < 4; i++) cycle("step_held");
        chk("step_once_addr", int'(address), 10);
        chk("step_once_halted", int'(halted), 1);
        step_req = 0;
        cycle("step_low");
        step_req = 1;
        cycle("step2_enter");
        cycle("step2_fetch");
        chk("step2_instr", int'(instr), 'hA00A);
        step_req = 0; run = 1; halt_req = 1;
        cycle("run_and_halt");
        cycle("run_and_halt2");
        chk("run_halt_stay", int'(halted), 1);

        // asynchronous reset mid-run
        halt_req = 0;
        cycle("run_again");
        jump_en = 1; jump_addr = 5'd13;
        cycle("jump13");
        jump_en = 0;
        #2 n_reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset_addr", int'(address), 0);
        #2 n_reset = 1'b1;

        // restart during run
        cycle("post_reset_enter");
        jump_en = 1; jump_addr = 5'd5;
        cycle("jump5");
        jump_en = 0; restart = 1;
        cycle("restart");
        chk("restart_addr", int'(address), 0);
        chk("restart_halted", int'(halted), 1);
        restart = 0; run = 0;

        // randomized phase
        for (int k = 0; k < DEPTH; k++) mem[k] = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            run        = ($urandom_range(0, 3) == 0);
            halt_req   = ($urandom_range(0, 15) == 0);
            step_req   = ($urandom_range(0, 2) == 0);
            restart    = ($urandom_range(0, 40) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            branch_en  = ($urandom_range(0, 4) == 0);
            jump_en    = ($urandom_range(0, 6) == 0);
            branch_off = PS'($urandom);
            jump_addr  = PS'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
